// File: rtl/cancid_pkg.sv
// ============================================================================
//  Module   : cancid_pkg
//  Purpose  : Shared constants and FSM state encoding for the cancid stream
//             sequencer and its per-stream context store.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cancid_pkg;

    localparam int STREAM_ID_W   = 6;
    localparam int NUM_STREAMS   = 64;
    localparam int LOAD_LAT_DEF  = 2;
    localparam int DRAIN_LAT_DEF = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;
    localparam state_t ST_EOP    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/cancid_stream_ctx.sv
// ============================================================================
//  Module   : cancid_stream_ctx
//  Purpose  : Per-stream regex enable masks and per-(stream, regex) seen bits
//             with an asynchronous read port and a write/set/clear port.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cancid_stream_ctx
    import cancid_pkg::*;
#(
    parameter int NUM_REGEX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STREAM_ID_W-1:0] i_rd_sid,
    output logic [NUM_REGEX-1:0]   o_rd_mask,
    output logic [NUM_REGEX-1:0]   o_rd_seen,
    input  logic                   i_cfg_we,
    input  logic [STREAM_ID_W-1:0] i_cfg_sid,
    input  logic [NUM_REGEX-1:0]   i_cfg_mask,
    input  logic                   i_set_seen,
    input  logic [STREAM_ID_W-1:0] i_set_sid,
    input  logic [NUM_REGEX-1:0]   i_set_mask,
    input  logic                   i_clear_seen
);

    logic [NUM_REGEX-1:0] r_enable_mem [NUM_STREAMS];
    logic [NUM_REGEX-1:0] r_seen       [NUM_STREAMS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                r_enable_mem[i] <= '1;
                r_seen[i]       <= '0;
            end
        end else begin
            if (i_cfg_we) begin
                r_enable_mem[i_cfg_sid] <= i_cfg_mask;
            end
            // A global clear takes priority over the end-of-packet seen update
            if (i_clear_seen) begin
                for (int i = 0; i < NUM_STREAMS; i++) begin
                    r_seen[i] <= '0;
                end
            end else if (i_set_seen) begin
                r_seen[i_set_sid] <= r_seen[i_set_sid] | i_set_mask;
            end
        end
    end

    assign o_rd_mask = r_enable_mem[i_rd_sid];
    assign o_rd_seen = r_seen[i_rd_sid];

endmodule

`default_nettype wire

// File: rtl/cancid_stream_sequencer.sv
// ============================================================================
//  Module   : cancid_stream_sequencer
//  Purpose  : Restores per-stream matcher context, streams packet bytes into
//             the regex matcher bank and issues a commit strobe per packet.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cancid_stream_sequencer
    import cancid_pkg::*;
#(
    parameter int NUM_REGEX = 8,
    parameter int LOAD_LAT  = LOAD_LAT_DEF,
    parameter int DRAIN_LAT = DRAIN_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pkt_vld,
    input  logic                   pkt_sop,
    input  logic                   pkt_eop,
    input  logic [7:0]             pkt_data,
    input  logic [STREAM_ID_W-1:0] pkt_stream_id,
    output logic                   pkt_rdy,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_stream_id,
    input  logic [NUM_REGEX-1:0]   cfg_mask,
    input  logic                   cfg_clear_seen,
    output logic                   load_state,
    output logic [NUM_REGEX-1:0]   new_stream_id,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic [NUM_REGEX-1:0]   enable,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic                   busy,
    output logic [15:0]            pkt_count,
    output logic [15:0]            drop_count
);

    localparam int c_CNT_W = 8;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_load_state;
    logic [NUM_REGEX-1:0]   r_new_stream_id;
    logic [STREAM_ID_W-1:0] r_stream_id;
    logic [NUM_REGEX-1:0]   r_enable;
    logic [7:0]             r_char_in;
    logic                   r_char_in_vld;
    logic                   r_eop;
    logic [15:0]            r_pkt_count;
    logic [15:0]            r_drop_count;

    logic [NUM_REGEX-1:0]   w_rd_mask;
    logic [NUM_REGEX-1:0]   w_rd_seen;
    logic                   w_drop;

    cancid_stream_ctx #(
        .NUM_REGEX (NUM_REGEX)
    ) u_ctx (
        .clk          (clk),
        .rst          (rst),
        .i_rd_sid     (pkt_stream_id),
        .o_rd_mask    (w_rd_mask),
        .o_rd_seen    (w_rd_seen),
        .i_cfg_we     (cfg_we),
        .i_cfg_sid    (cfg_stream_id),
        .i_cfg_mask   (cfg_mask),
        .i_set_seen   (r_state == ST_EOP),
        .i_set_sid    (r_stream_id),
        .i_set_mask   (r_enable),
        .i_clear_seen (cfg_clear_seen)
    );

    assign w_drop  = (r_state == ST_IDLE) && pkt_vld && !pkt_sop;
    assign pkt_rdy = (r_state == ST_STREAM) || w_drop;
    assign busy    = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_load_state    <= 1'b0;
            r_new_stream_id <= '0;
            r_stream_id     <= '0;
            r_enable        <= '0;
            r_char_in       <= '0;
            r_char_in_vld   <= 1'b0;
            r_eop           <= 1'b0;
            r_pkt_count     <= '0;
            r_drop_count    <= '0;
        end else begin
            r_load_state    <= 1'b0;
            r_new_stream_id <= '0;
            r_char_in_vld   <= 1'b0;
            r_eop           <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The sop beat itself stays on the bus and is consumed in STREAM
                    if (pkt_vld && pkt_sop) begin
                        r_state         <= ST_LOAD;
                        r_stream_id     <= pkt_stream_id;
                        r_enable        <= w_rd_mask;
                        r_new_stream_id <= ~w_rd_seen;
                        r_load_state    <= 1'b1;
                    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                end
                ST_LOAD: begin
                    // STREAM accepts one cycle before the first char appears,
                    // so WAIT covers LOAD_LAT-1 of the idle cycles
                    if (LOAD_LAT > 1) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= c_CNT_W'(LOAD_LAT - 2);
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_STREAM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (pkt_vld) begin
                        r_char_in     <= pkt_data;
                        r_char_in_vld <= 1'b1;
                        if (pkt_eop) begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= c_CNT_W'(DRAIN_LAT - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_EOP;
                        r_eop   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_EOP: begin
                    r_state     <= ST_IDLE;
                    r_pkt_count <= r_pkt_count + 16'd1;
                    r_stream_id <= '0;
                    r_enable    <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_state    = r_load_state;
    assign new_stream_id = r_new_stream_id;
    assign stream_id     = r_stream_id;
    assign enable        = r_enable;
    assign char_in       = r_char_in;
    assign char_in_vld   = r_char_in_vld;
    assign eop           = r_eop;
    assign pkt_count     = r_pkt_count;
    assign drop_count    = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_cancid_stream_sequencer.sv
// ============================================================================
//  Module   : tb_cancid_stream_sequencer
//  Purpose  : Directed self-checking bench for cancid_stream_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cancid_stream_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
    logic [7:0] pkt_data = 8'h00;
    logic [5:0] pkt_stream_id = 6'd0;
    logic       pkt_rdy;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_stream_id = 6'd0;
    logic [7:0] cfg_mask = 8'h00;
    logic       cfg_clear_seen = 1'b0;
    logic       load_state;
    logic [7:0] new_stream_id;
    logic [5:0] stream_id;
    logic [7:0] enable;
    logic [7:0] char_in;
    logic       char_in_vld;
    logic       eop;
    logic       busy;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    cancid_stream_sequencer #(
        .NUM_REGEX (8),
        .LOAD_LAT  (2),
        .DRAIN_LAT (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_vld        (pkt_vld),
        .pkt_sop        (pkt_sop),
        .pkt_eop        (pkt_eop),
        .pkt_data       (pkt_data),
        .pkt_stream_id  (pkt_stream_id),
        .pkt_rdy        (pkt_rdy),
        .cfg_we         (cfg_we),
        .cfg_stream_id  (cfg_stream_id),
        .cfg_mask       (cfg_mask),
        .cfg_clear_seen (cfg_clear_seen),
        .load_state     (load_state),
        .new_stream_id  (new_stream_id),
        .stream_id      (stream_id),
        .enable         (enable),
        .char_in        (char_in),
        .char_in_vld    (char_in_vld),
        .eop            (eop),
        .busy           (busy),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    logic [7:0] q_ch [$];
    int         q_cyc [$];
    int         n_load = 0, load_cyc = 0, n_eop = 0, eop_cyc = 0;
    logic [7:0] load_nsid = 0, load_en = 0, eop_en = 0;
    logic [5:0] load_sid = 0, eop_sid = 0;

    always @(negedge clk) begin
        if (load_state) begin
            n_load++;
            load_cyc  = cyc;
            load_nsid = new_stream_id;
            load_sid  = stream_id;
            load_en   = enable;
        end
        if (char_in_vld) begin
            q_ch.push_back(char_in);
            q_cyc.push_back(cyc);
        end
        if (eop) begin
            n_eop++;
            eop_cyc = cyc;
            eop_sid = stream_id;
            eop_en  = enable;
        end
    end

    int n_chk = 0, n_fail = 0;
    int exp_pkts = 0;
    int sop_cyc = 0;
    int base = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_pkt(input logic [5:0] sid, input string s, input int gap_at, input int gap_len);
        bit acc;
        int guard;
        base = q_ch.size();
        for (int i = 0; i < s.len(); i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    pkt_vld = 1'b0;
                end
            end
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                pkt_vld       = 1'b1;
                pkt_sop       = (i == 0);
                pkt_eop       = (i == s.len() - 1);
                pkt_data      = s[i];
                pkt_stream_id = sid;
                if (i == 0 && guard == 0) sop_cyc = cyc;
                #1;
                acc = pkt_rdy;
                guard++;
                if (!acc && guard > 40) begin
                    check_eq("rdy_timeout", 0, 1);
                    pkt_vld = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        pkt_vld = 1'b0;
        pkt_sop = 1'b0;
        pkt_eop = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input logic [5:0] sid, input string s,
                           input int gap_at, input int gap_len,
                           input logic [7:0] exp_nsid, input logic [7:0] exp_en);
        int nl, ne, k, last;
        nl = n_load;
        ne = n_eop;
        send_pkt(sid, s, gap_at, gap_len);
        k = 0;
        while (n_eop == ne && k < 60) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_eop_seen"}, n_eop, ne + 1);
        check_eq({tag, "_load_once"}, n_load, nl + 1);
        check_eq({tag, "_load_lat"}, load_cyc - sop_cyc, 1);
        check_eq({tag, "_load_sid"}, load_sid, sid);
        check_eq({tag, "_nsid"}, load_nsid, exp_nsid);
        check_eq({tag, "_enable"}, load_en, exp_en);
        check_eq({tag, "_nchars"}, q_ch.size() - base, s.len());
        if (q_ch.size() - base == s.len()) begin
            check_eq({tag, "_first_char_lat"}, q_cyc[base] - sop_cyc, 4);
            for (int i = 0; i < s.len(); i++) begin
                check_eq({tag, "_char"}, q_ch[base + i], s[i]);
                if (i > 0)
                    check_eq({tag, "_char_gap"}, q_cyc[base + i] - q_cyc[base + i - 1],
                             (i == gap_at) ? gap_len + 1 : 1);
            end
            last = q_cyc[base + s.len() - 1];
            check_eq({tag, "_eop_lat"}, eop_cyc - last, 3);
        end
        check_eq({tag, "_eop_sid"}, eop_sid, sid);
        check_eq({tag, "_eop_en"}, eop_en, exp_en);
        exp_pkts++;
        @(negedge clk);
        check_eq({tag, "_pkt_count"}, pkt_count, exp_pkts);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int ne, guard;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_load_state", load_state, 0);
        check_eq("rst_char_vld", char_in_vld, 0);
        check_eq("rst_eop", eop, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdy", pkt_rdy, 0);
        check_eq("rst_sid_en", {stream_id, enable}, 0);
        check_eq("rst_counts", {pkt_count, drop_count}, 0);

        run_pkt("new_stream", 6'd5, "MAIL", -1, 0, 8'hFF, 8'hFF);
        run_pkt("resumed", 6'd5, "ABC", -1, 0, 8'h00, 8'hFF);

        @(negedge clk);
        cfg_we = 1'b1; cfg_stream_id = 6'd9; cfg_mask = 8'h0F;
        @(negedge clk);
        cfg_we = 1'b0;
        run_pkt("masked1", 6'd9, "RE", -1, 0, 8'hFF, 8'h0F);
        run_pkt("masked2", 6'd9, "GX", -1, 0, 8'hF0, 8'h0F);

        run_pkt("stall", 6'd20, "WXYZ", 2, 2, 8'hFF, 8'hFF);
        run_pkt("one_byte", 6'd7, "Q", -1, 0, 8'hFF, 8'hFF);

        // Non-sop beats in IDLE are accepted and discarded
        ne = n_load;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = 8'h55;
            #1;
            check_eq("drop_rdy", pkt_rdy, 1);
        end
        @(negedge clk);
        pkt_vld = 1'b0;
        @(negedge clk);
        check_eq("drop_count", drop_count, 3);
        check_eq("drop_no_load", n_load, ne);
        check_eq("drop_not_busy", busy, 0);

        @(negedge clk);
        cfg_clear_seen = 1'b1;
        @(negedge clk);
        cfg_clear_seen = 1'b0;
        run_pkt("after_clear", 6'd5, "OK", -1, 0, 8'hFF, 8'hFF);

        // Abort a packet with reset mid-stream
        ne = n_eop;
        base = q_ch.size();
        @(negedge clk);
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_stream_id = 6'd11; pkt_data = "H";
        guard = 0;
        while (q_ch.size() - base < 2 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check_eq("abort_streaming", (q_ch.size() - base >= 2), 1);
        rst = 1'b1;
        pkt_vld = 1'b0; pkt_sop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_pkts = 0;
        check_eq("abort_outputs", {load_state, char_in_vld, eop, busy}, 0);
        check_eq("abort_sid_en", {stream_id, enable}, 0);
        check_eq("abort_counts", {pkt_count, drop_count}, 0);
        repeat (10) @(negedge clk);
        check_eq("abort_no_eop", n_eop, ne);
        run_pkt("post_rst_s5", 6'd5, "NEW", -1, 0, 8'hFF, 8'hFF);
        run_pkt("post_rst_s9", 6'd9, "M", -1, 0, 8'hFF, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
